arm_mc_controller: RTL and testbench
====================================

ARM_MC_CONTROLLER -- requirements
Module: arm_mc_controller

Interface
REQ-001 The block SHALL have no parameters; state encoding is fixed by REQ-012.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 Cond  input  4  Instr[31:28], condition field.
REQ-005 Op  input  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-006 Funct  input  6  Instr[25:20]: [5] I, [4:1] cmd, [0] S or L.
REQ-007 Rd  input  4  Instr[15:12], destination register.
REQ-008 ALUFlags  input  4  NZCV from the ALU this cycle.
REQ-009 Outputs SHALL be PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc (1 bit each); ResultSrc, ALUSrcB, ALUControl (2 bits each); ALUSrcA (1 bit); State (4 bits, debug).

Function
REQ-010 The block SHALL be a Moore main FSM plus a combinational ALU decoder, a flags register, and a CondEx latch.
REQ-011 Each instruction SHALL start in FETCH; the FSM returns to FETCH after the last state of each instruction.
REQ-012 State encoding SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9; codes 10-15 SHALL go to FETCH next cycle.
REQ-013 Transitions: FETCH->DECODE.
REQ-014 DECODE transitions: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH.
REQ-015 MEMADR -> MEMRD if Funct[0]=1, else MEMWR; MEMRD -> MEMWB; EXECUTER/EXECUTEI -> ALUWB; MEMWB, MEMWR, ALUWB, BRANCH -> FETCH.
REQ-016 Per-state controls; unlisted controls are 0:
- FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1.
- EXECUTER: ALUOp=1.
- EXECUTEI: ALUSrcB=01, ALUOp=1.
- ALUWB: RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-017 ALUOp=0 SHALL give ALUControl=00 (add).
REQ-018 When ALUOp=1, Funct[4:1] SHALL select ALUControl: 0100 ADD -> 00, 0010 SUB -> 01, 0000 AND -> 10, 1100 ORR -> 11, any other cmd -> 00 with FlagW=00.
REQ-019 When ALUOp=1, FlagW[1]=Funct[0]; FlagW[0]=Funct[0] AND (ADD or SUB).
REQ-020 CondEx SHALL be computed from Cond against the flags register (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL); Cond=1111 SHALL give CondEx=0.
REQ-021 CondExReg SHALL capture CondEx on the DECODE->next-state edge and hold it until the next DECODE.
REQ-022 Flags[3:2] SHALL load ALUFlags[3:2] at the end of EXECUTER/EXECUTEI when FlagW[1] AND CondExReg; Flags[1:0] SHALL load ALUFlags[1:0] when FlagW[0] AND CondExReg.
REQ-023 RegWrite = RegW AND CondExReg.
REQ-024 MemWrite = MemW AND CondExReg.
REQ-025 PCWrite = NextPC OR (Branch AND CondExReg) OR (RegW AND CondExReg AND Rd=1111).
REQ-026 Instruction latency SHALL be: branch 3 cycles, data-processing 4, STR 4, LDR 5, Op=11 2 (no writes).

Reset
REQ-027 While reset=0, State SHALL be FETCH, Flags=0000, CondExReg=0, and PCWrite, MemWrite, RegWrite, IRWrite SHALL be forced 0 asynchronously.
REQ-028 Reset asserted mid-instruction SHALL abort it with no write enables asserted; after release, the first rising edge SHALL execute FETCH with IRWrite=1, PCWrite=1.

Verification
REQ-029 ADD R2,R0,#5 (E2802005) -> State 0,1,7,8; ALUControl=00 in EXECUTEI; RegWrite=1 only in ALUWB; flags unchanged.
REQ-030 LDR (Op=01, Funct=011001) -> 0,1,2,3,4, with AdrSrc=1 in MEMRD and RegWrite=1 in MEMWB; STR (Funct=011000) -> 0,1,2,5, with MemWrite=1 for exactly one cycle.
REQ-031 SUBS giving ALUFlags=0100, then BEQ -> Flags=0100 and PCWrite=1 in BRANCH; BNE after the same SUBS -> PCWrite=0 in BRANCH.
REQ-032 ADDNE with Z=1 -> ALUWB reached with RegWrite=0; ADD to Rd=15 (AL) -> PCWrite=1 and RegWrite=1 in ALUWB.
REQ-033 Reset low during MEMRD -> State=0 immediately with all enables 0; Op=11 -> DECODE->FETCH with no write; forced State=12 -> FETCH next cycle.

Source files
------------

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: Moore main FSM, ALU decoder, NZCV flags register
// and latched condition-pass bit that qualifies register, memory and PC writes.
module arm_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic       ALUSrcA,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_e;

  // Kept as a plain vector so unused codes 10-15 remain representable.
  logic [3:0] state_r;
  logic [3:0] next_state_s;
  logic [3:0] flags_r;
  logic       cond_ex_r;
  logic       cond_ex_s;

  logic       next_pc_s;
  logic       branch_s;
  logic       reg_w_s;
  logic       mem_w_s;
  logic       ir_write_s;
  logic       adr_src_s;
  logic [1:0] result_src_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic       alu_op_s;
  logic [1:0] alu_control_s;
  logic [1:0] flag_w_s;

  // Flags are ordered {N, Z, C, V}; the never condition (1111) fails.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic pass;
    {n, z, c, v} = flags;
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  assign cond_ex_s = cond_check(Cond, flags_r);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH:  next_state_s = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   next_state_s = MEMADR;
          2'b00:   next_state_s = Funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   next_state_s = BRANCH;
          default: next_state_s = FETCH;
        endcase
      end
      MEMADR:   next_state_s = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    next_state_s = MEMWB;
      EXECUTER: next_state_s = ALUWB;
      EXECUTEI: next_state_s = ALUWB;
      default:  next_state_s = FETCH;
    endcase
  end

  // Moore control decode per state
  always_comb begin
    next_pc_s    = 1'b0;
    branch_s     = 1'b0;
    reg_w_s      = 1'b0;
    mem_w_s      = 1'b0;
    ir_write_s   = 1'b0;
    adr_src_s    = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 1'b0;
    case (state_r)
      FETCH: begin
        ir_write_s   = 1'b1;
        next_pc_s    = 1'b1;
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
      end
      DECODE: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
      end
      MEMADR: alu_src_b_s = 2'b01;
      MEMRD:  adr_src_s = 1'b1;
      MEMWB: begin
        result_src_s = 2'b01;
        reg_w_s      = 1'b1;
      end
      MEMWR: begin
        adr_src_s = 1'b1;
        mem_w_s   = 1'b1;
      end
      EXECUTER: alu_op_s = 1'b1;
      EXECUTEI: begin
        alu_src_b_s = 2'b01;
        alu_op_s    = 1'b1;
      end
      ALUWB: reg_w_s = 1'b1;
      BRANCH: begin
        alu_src_b_s  = 2'b01;
        result_src_s = 2'b10;
        branch_s     = 1'b1;
      end
      default: begin
        next_pc_s = 1'b0;
      end
    endcase
  end

  // ALU decoder; only ADD/SUB may write C and V
  always_comb begin
    alu_control_s = 2'b00;
    flag_w_s      = 2'b00;
    if (alu_op_s) begin
      case (Funct[4:1])
        4'b0100: begin
          alu_control_s = 2'b00;
          flag_w_s      = {Funct[0], Funct[0]};
        end
        4'b0010: begin
          alu_control_s = 2'b01;
          flag_w_s      = {Funct[0], Funct[0]};
        end
        4'b0000: begin
          alu_control_s = 2'b10;
          flag_w_s      = {Funct[0], 1'b0};
        end
        4'b1100: begin
          alu_control_s = 2'b11;
          flag_w_s      = {Funct[0], 1'b0};
        end
        default: begin
          alu_control_s = 2'b00;
          flag_w_s      = 2'b00;
        end
      endcase
    end else begin
      alu_control_s = 2'b00;
      flag_w_s      = 2'b00;
    end
  end

  // Condition-pass latch, sampled as DECODE completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cond_ex_r <= 1'b0;
    end else if (state_r == DECODE) begin
      cond_ex_r <= cond_ex_s;
    end
  end

  // Flags register: NZ and CV halves update independently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_r <= 4'b0000;
    end else begin
      if (flag_w_s[1] && cond_ex_r) begin
        flags_r[3:2] <= ALUFlags[3:2];
      end
      if (flag_w_s[0] && cond_ex_r) begin
        flags_r[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Write enables are gated by reset so an aborted instruction writes nothing.
  assign PCWrite    = reset & (next_pc_s | (branch_s & cond_ex_r) |
                               (reg_w_s & cond_ex_r & (Rd == 4'b1111)));
  assign MemWrite   = reset & mem_w_s & cond_ex_r;
  assign RegWrite   = reset & reg_w_s & cond_ex_r;
  assign IRWrite    = reset & ir_write_s;
  assign AdrSrc     = adr_src_s;
  assign ResultSrc  = result_src_s;
  assign ALUSrcB    = alu_src_b_s;
  assign ALUControl = alu_control_s;
  assign ALUSrcA    = alu_src_a_s;
  assign State      = state_r;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed per-cycle vector bench for arm_mc_controller plus reset/abort and
// illegal-state sequences.
module tb_arm_mc_controller;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl;
  logic [3:0] State;
  logic [15:0] act;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  af;
    logic [15:0] exp;
  } vec_t;

  vec_t  vecs[$];
  string names[$];

  arm_mc_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ALUSrcA(ALUSrcA), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
                ResultSrc, ALUSrcB, ALUControl, ALUSrcA};

  // Packs {State,PCW,MemW,RegW,IRW,AdrSrc,ResultSrc,ALUSrcB,ALUControl,ALUSrcA}
  function automatic logic [15:0] e(input logic [3:0] st, input logic pcw,
                                    input logic memw, input logic regw,
                                    input logic irw, input logic adr,
                                    input logic [1:0] res, input logic [1:0] srcb,
                                    input logic [1:0] aluc, input logic srca);
    return {st, pcw, memw, regw, irw, adr, res, srcb, aluc, srca};
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    total_cnt++;
    if (got === want) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic add(input string nm, input logic [3:0] c, input logic [1:0] o,
                     input logic [5:0] f, input logic [3:0] r, input logic [3:0] a,
                     input logic [15:0] ex);
    vec_t v;
    v.cond = c; v.op = o; v.funct = f; v.rd = r; v.af = a; v.exp = ex;
    vecs.push_back(v);
    names.push_back(nm);
  endtask

  task automatic fd(input string nm, input logic [3:0] c, input logic [1:0] o,
                    input logic [5:0] f, input logic [3:0] r, input logic [3:0] a);
    add({nm, "_fetch"}, c, o, f, r, a,
        e(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1));
    add({nm, "_decode"}, c, o, f, r, a,
        e(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1));
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic [3:0] a);
    Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fe_exp;
    logic [15:0] br0_exp;
    pass_cnt  = 0;
    total_cnt = 0;
    fe_exp  = e(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1);
    br0_exp = e(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0);

    // ADD R2,R0,#5 (S=0): flags must stay 0000 despite ALUFlags=1111
    fd("add_imm", 4'hE, 2'b00, 6'b101000, 4'h2, 4'b1111);
    add("add_imm_exi", 4'hE, 2'b00, 6'b101000, 4'h2, 4'b1111,
        e(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0));
    add("add_imm_wb", 4'hE, 2'b00, 6'b101000, 4'h2, 4'b1111,
        e(4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
    // SUBS -> flags 0100
    fd("subs", 4'hE, 2'b00, 6'b000101, 4'h3, 4'b0100);
    add("subs_exr", 4'hE, 2'b00, 6'b000101, 4'h3, 4'b0100,
        e(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0));
    add("subs_wb", 4'hE, 2'b00, 6'b000101, 4'h3, 4'b0100,
        e(4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
    fd("beq", 4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000);
    add("beq_taken", 4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000,
        e(4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0));
    fd("bne", 4'h1, 2'b10, 6'b100000, 4'h0, 4'b0000);
    add("bne_not_taken", 4'h1, 2'b10, 6'b100000, 4'h0, 4'b0000, br0_exp);
    // ADDNE with Z=1: no register write
    fd("addne", 4'h1, 2'b00, 6'b101000, 4'h2, 4'b0000);
    add("addne_exi", 4'h1, 2'b00, 6'b101000, 4'h2, 4'b0000,
        e(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0));
    add("addne_wb", 4'h1, 2'b00, 6'b101000, 4'h2, 4'b0000,
        e(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
    // ADD to R15 writes the PC as well
    fd("add_pc", 4'hE, 2'b00, 6'b101000, 4'hF, 4'b0000);
    add("add_pc_exi", 4'hE, 2'b00, 6'b101000, 4'hF, 4'b0000,
        e(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0));
    add("add_pc_wb", 4'hE, 2'b00, 6'b101000, 4'hF, 4'b0000,
        e(4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
    fd("ldr", 4'hE, 2'b01, 6'b011001, 4'h4, 4'b0000);
    add("ldr_memadr", 4'hE, 2'b01, 6'b011001, 4'h4, 4'b0000,
        e(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0));
    add("ldr_memrd", 4'hE, 2'b01, 6'b011001, 4'h4, 4'b0000,
        e(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0));
    add("ldr_memwb", 4'hE, 2'b01, 6'b011001, 4'h4, 4'b0000,
        e(4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0));
    fd("str", 4'hE, 2'b01, 6'b011000, 4'h4, 4'b0000);
    add("str_memadr", 4'hE, 2'b01, 6'b011000, 4'h4, 4'b0000,
        e(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0));
    add("str_memwr", 4'hE, 2'b01, 6'b011000, 4'h4, 4'b0000,
        e(4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0));
    fd("orr", 4'hE, 2'b00, 6'b011000, 4'h5, 4'b1111);
    add("orr_exr", 4'hE, 2'b00, 6'b011000, 4'h5, 4'b1111,
        e(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0));
    add("orr_wb", 4'hE, 2'b00, 6'b011000, 4'h5, 4'b1111,
        e(4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
    // ANDS with ALUFlags=1010: only N,Z load -> flags 1000
    fd("ands", 4'hE, 2'b00, 6'b100001, 4'h6, 4'b1010);
    add("ands_exi", 4'hE, 2'b00, 6'b100001, 4'h6, 4'b1010,
        e(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0));
    add("ands_wb", 4'hE, 2'b00, 6'b100001, 4'h6, 4'b1010,
        e(4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
    fd("bmi", 4'h4, 2'b10, 6'b100000, 4'h0, 4'b0000);
    add("bmi_taken", 4'h4, 2'b10, 6'b100000, 4'h0, 4'b0000,
        e(4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0));
    fd("bcs", 4'h2, 2'b10, 6'b100000, 4'h0, 4'b0000);
    add("bcs_not_taken", 4'h2, 2'b10, 6'b100000, 4'h0, 4'b0000, br0_exp);
    fd("blt", 4'hB, 2'b10, 6'b100000, 4'h0, 4'b0000);
    add("blt_taken", 4'hB, 2'b10, 6'b100000, 4'h0, 4'b0000,
        e(4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0));
    // Unsupported cmd with S=1: ALUControl 00 and no flag write
    fd("eors", 4'hE, 2'b00, 6'b000011, 4'h7, 4'b1111);
    add("eors_exr", 4'hE, 2'b00, 6'b000011, 4'h7, 4'b1111,
        e(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
    add("eors_wb", 4'hE, 2'b00, 6'b000011, 4'h7, 4'b1111,
        e(4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
    fd("beq2", 4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000);
    add("beq2_not_taken", 4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000, br0_exp);
    fd("bvs", 4'h6, 2'b10, 6'b100000, 4'h0, 4'b0000);
    add("bvs_not_taken", 4'h6, 2'b10, 6'b100000, 4'h0, 4'b0000, br0_exp);
    fd("bnv", 4'hF, 2'b10, 6'b100000, 4'h0, 4'b0000);
    add("bnv_not_taken", 4'hF, 2'b10, 6'b100000, 4'h0, 4'b0000, br0_exp);
    fd("undef", 4'hE, 2'b11, 6'b000000, 4'h0, 4'b0000);
    add("undef_refetch", 4'hE, 2'b11, 6'b000000, 4'h0, 4'b0000, fe_exp);

    // Reset state
    reset = 1'b0;
    drive(4'hE, 2'b01, 6'b011001, 4'h4, 4'b0000);
    #2;
    chk("reset_state_enables", {8'h00, act[15:8]}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", {8'h00, act[15:8]}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cond, vecs[i].op, vecs[i].funct, vecs[i].rd, vecs[i].af);
      #1;
      chk(names[i], act, vecs[i].exp);
      @(negedge clk);
    end

    // Now in DECODE of the undefined op; switch to LDR and abort in MEMRD
    drive(4'hE, 2'b01, 6'b011001, 4'h4, 4'b0000);
    #1;
    chk("abort_decode", {12'h000, State}, 16'h0001);
    @(negedge clk);
    #1;
    chk("abort_memadr", {12'h000, State}, 16'h0002);
    @(negedge clk);
    #1;
    chk("abort_memrd", act, e(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0));
    reset = 1'b0;
    #1;
    chk("abort_async", {8'h00, act[15:8]}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    drive(4'h4, 2'b10, 6'b100000, 4'h0, 4'b0000);
    #1;
    chk("post_reset_fetch", act, fe_exp);
    @(negedge clk);
    #1;
    chk("post_reset_decode", {12'h000, State}, 16'h0001);
    @(negedge clk);
    #1;
    chk("post_reset_bmi_flags_clear", act, br0_exp);
    @(negedge clk);

    // Illegal state code recovers to FETCH
    force dut.state_r = 4'd12;
    #1;
    release dut.state_r;
    #1;
    chk("illegal_state_loaded", {12'h000, State}, 16'h000C);
    @(posedge clk);
    #1;
    chk("illegal_state_recover", {12'h000, State}, 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
